// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: defaults, FSM states
// and a requester lane selector.
package uart_pkg;

  localparam int unsigned N_REQ_DEF     = 4;
  localparam int unsigned START_TMO_DEF = 16;
  localparam int unsigned MAX_RETRY_DEF = 3;
  localparam int unsigned HOLD_TMO_DEF  = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_ACK,
    S_HOLD
  } state_t;

  function automatic logic [7:0] lane_byte(input logic [8*N_REQ_DEF-1:0] data,
                                           input logic [1:0]             idx);
    return data[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester and UART-side signals of the transmit scheduler; master is the
// scheduler, slave is the environment (requesters plus UART transmitter).
interface uart_tx_sched_if;
  import uart_pkg::*;

  logic [N_REQ_DEF-1:0]   req;
  logic [8*N_REQ_DEF-1:0] req_data;
  logic [N_REQ_DEF-1:0]   req_last;
  logic [N_REQ_DEF-1:0]   req_ack;
  logic [7:0]             uart_idata;
  logic                   uart_newTxData;
  logic                   uart_txBusy;
  logic [1:0]             grant;
  logic                   grant_valid;
  logic                   drop_err;
  logic [1:0]             drop_id;

  modport master (
    input  req, req_data, req_last, uart_txBusy,
    output req_ack, uart_idata, uart_newTxData, grant, grant_valid, drop_err, drop_id
  );

  modport slave (
    output req, req_data, req_last, uart_txBusy,
    input  req_ack, uart_idata, uart_newTxData, grant, grant_valid, drop_err, drop_id
  );

endinterface

// File: rtl/uart_tx_sched_rr_pick4.sv
// Four-way round-robin select: first asserted request after ptr, wrapping.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any
);

  // Scan lowest priority first so the highest-priority hit overwrites.
  always_comb begin
    idx = '0;
    any = |req;
    for (int unsigned k = 4; k > 0; k--) begin
      if (req[ptr + 2'(k)]) idx = ptr + 2'(k);
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-locking round-robin scheduler feeding one UART transmitter, with
// load retry/drop and an idle-hold timeout on locked packets.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ     = N_REQ_DEF,
  parameter int unsigned START_TMO = START_TMO_DEF,
  parameter int unsigned MAX_RETRY = MAX_RETRY_DEF,
  parameter int unsigned HOLD_TMO  = HOLD_TMO_DEF
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_sched_if.master bus
);

  localparam int unsigned TMO_MAX = (START_TMO > HOLD_TMO) ? START_TMO : HOLD_TMO;
  localparam int unsigned TMO_W   = $clog2(TMO_MAX + 1);
  localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TMO_W-1:0] START_LIM = TMO_W'(START_TMO - 1);
  localparam logic [TMO_W-1:0] HOLD_LIM  = TMO_W'(HOLD_TMO - 1);
  localparam logic [RTY_W-1:0] RTY_LIM   = RTY_W'(MAX_RETRY);

  state_t             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic               gv_q, gv_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [7:0]         idata_q, idata_d;
  logic               lock_q, lock_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               new_tx_q, new_tx_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               drop_err_q, drop_err_d;
  logic [1:0]         drop_id_q, drop_id_d;

  logic [1:0]         pick_idx;
  logic               pick_any;

  rr_pick4 u_pick (
    .req (bus.req),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Every output is the flop image of a *_d value computed one cycle earlier,
  // so pulses are asserted on the edge that enters the state they belong to.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gv_d       = gv_q;
    rr_ptr_d   = rr_ptr_q;
    idata_d    = idata_q;
    lock_d     = lock_q;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    new_tx_d   = 1'b0;
    ack_d      = '0;
    drop_err_d = 1'b0;
    drop_id_d  = drop_id_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          grant_d  = pick_idx;
          gv_d     = 1'b1;
          idata_d  = lane_byte(bus.req_data, pick_idx);
          lock_d   = bus.req_last[pick_idx];
          retry_d  = '0;
          tmo_d    = '0;
          new_tx_d = 1'b1;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
        state_d = S_WAIT_BUSY;
      end

      S_WAIT_BUSY: begin
        if (bus.uart_txBusy) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_q >= START_LIM) begin
          if (retry_q < RTY_LIM) begin
            retry_d  = retry_q + 1'b1;
            tmo_d    = '0;
            new_tx_d = 1'b1;
            state_d  = S_LOAD;
          end else begin
            drop_err_d      = 1'b1;
            drop_id_d       = grant_q;
            ack_d[grant_q]  = 1'b1;
            state_d         = S_ACK;
          end
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_WAIT_DONE: begin
        if (!bus.uart_txBusy) begin
          ack_d[grant_q] = 1'b1;
          state_d        = S_ACK;
        end
      end

      S_ACK: begin
        rr_ptr_d = grant_q;
        if (lock_q || drop_err_q) begin
          gv_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          // Hold counter measures cycles since the ACK cycle.
          tmo_d   = TMO_W'(1);
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (bus.req[grant_q]) begin
          idata_d  = lane_byte(bus.req_data, grant_q);
          lock_d   = bus.req_last[grant_q];
          retry_d  = '0;
          tmo_d    = '0;
          new_tx_d = 1'b1;
          state_d  = S_LOAD;
        end else if (tmo_q >= HOLD_LIM) begin
          gv_d    = 1'b0;
          state_d = S_IDLE;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: begin
        gv_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      gv_q       <= 1'b0;
      rr_ptr_q   <= 2'd3;
      idata_q    <= '0;
      lock_q     <= 1'b0;
      retry_q    <= '0;
      tmo_q      <= '0;
      new_tx_q   <= 1'b0;
      ack_q      <= '0;
      drop_err_q <= 1'b0;
      drop_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gv_q       <= gv_d;
      rr_ptr_q   <= rr_ptr_d;
      idata_q    <= idata_d;
      lock_q     <= lock_d;
      retry_q    <= retry_d;
      tmo_q      <= tmo_d;
      new_tx_q   <= new_tx_d;
      ack_q      <= ack_d;
      drop_err_q <= drop_err_d;
      drop_id_q  <= drop_id_d;
    end
  end

  assign bus.req_ack        = ack_q;
  assign bus.uart_idata     = idata_q;
  assign bus.uart_newTxData = new_tx_q;
  assign bus.grant          = grant_q;
  assign bus.grant_valid    = gv_q;
  assign bus.drop_err       = drop_err_q;
  assign bus.drop_id        = drop_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: requester and UART models plus
// directed timing checks around arbitration, retry, hold and reset.
module tb_uart_tx_sched;
  import uart_pkg::*;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       last;
  } pend_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       drop;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_en = 1'b1;
  int   busy_len = 6;
  int   n_total = 0;
  int   n_bad = 0;

  pend_t pend[$];
  exp_t  exp_q[$];

  uart_tx_sched_if bus ();

  uart_tx_sched #(
    .N_REQ     (4),
    .START_TMO (16),
    .MAX_RETRY (3),
    .HOLD_TMO  (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_rst_outputs();
    chk("rst_req_ack", 32'(bus.req_ack), 0);
    chk("rst_new_tx", 32'(bus.uart_newTxData), 0);
    chk("rst_idata", 32'(bus.uart_idata), 0);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_grant_valid", 32'(bus.grant_valid), 0);
    chk("rst_drop_err", 32'(bus.drop_err), 0);
    chk("rst_drop_id", 32'(bus.drop_id), 0);
  endtask

  // Requester model: each requester presents its oldest queued byte and
  // retires it when its ack pulse is seen.
  task automatic consume(input int i);
    int  k = 0;
    bit  done = 1'b0;
    while (!done && k < pend.size()) begin
      if (pend[k].id == 2'(i)) begin
        pend.delete(k);
        done = 1'b1;
      end else begin
        k++;
      end
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      bit found = 1'b0;
      bus.req[i]  = 1'b0;
      for (int k = 0; k < pend.size(); k++) begin
        if (!found && pend[k].id == 2'(i)) begin
          found              = 1'b1;
          bus.req[i]         = 1'b1;
          bus.req_data[8*i +: 8] = pend[k].data;
          bus.req_last[i]    = pend[k].last;
        end
      end
    end
  endtask

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
        if (!reset && bus.req_ack[i]) consume(i);
      end
      drive_reqs();
    end
  end

  // UART model: busy rises the cycle after a load strobe, lasts busy_len.
  initial begin
    int  cnt;
    bit  pend_start;
    cnt = 0;
    pend_start = 1'b0;
    bus.uart_txBusy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        cnt = 0;
        pend_start = 1'b0;
        bus.uart_txBusy = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.uart_txBusy = 1'b0;
      end else if (pend_start) begin
        pend_start = 1'b0;
        cnt = busy_len;
        bus.uart_txBusy = 1'b1;
      end
      if (!reset && bus.uart_newTxData && uart_en) pend_start = 1'b1;
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (bus.uart_newTxData) chk("load_while_busy", 32'(bus.uart_txBusy), 0);
        if (bus.req_ack != '0) begin
          if (exp_q.size() == 0) begin
            chk("ack_unexpected", 32'(bus.req_ack), 0);
          end else begin
            e = exp_q.pop_front();
            chk("ack_id", 32'(bus.req_ack), 32'(1) << e.id);
            chk("ack_data", 32'(bus.uart_idata), 32'(e.data));
            chk("ack_drop", 32'(bus.drop_err), 32'(e.drop));
            if (e.drop) chk("drop_id", 32'(bus.drop_id), 32'(e.id));
          end
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    pend.delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || pend.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n_load;
    int load_cyc[8];
    int drop_cyc;
    int ack_cnt;
    bit seen;
    bit done;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk_rst_outputs();
    reset = 1'b0;

    // Single byte on requester 2
    apply_reset();
    pend.push_back('{id: 2'd2, data: 8'hA5, last: 1'b1});
    exp_q.push_back('{id: 2'd2, data: 8'hA5, drop: 1'b0});
    @(posedge clk);
    #1;
    chk("single_new_tx", 32'(bus.uart_newTxData), 1);
    chk("single_idata", 32'(bus.uart_idata), 32'hA5);
    chk("single_grant", 32'(bus.grant), 2);
    chk("single_grant_valid", 32'(bus.grant_valid), 1);
    @(posedge clk);
    #1;
    chk("single_new_tx_once", 32'(bus.uart_newTxData), 0);
    seen = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (bus.uart_txBusy) seen = 1'b1;
      else if (seen) begin
        chk("single_ack_latency", 32'(bus.req_ack), 32'h4);
        done = 1'b1;
      end
      if (!done) begin
        @(posedge clk);
        #1;
      end
    end
    chk("single_busy_fall_seen", 32'(done), 1);
    @(posedge clk);
    #1;
    chk("single_ack_one_cycle", 32'(bus.req_ack), 0);
    chk("single_release", 32'(bus.grant_valid), 0);
    wait_drain(20, "single_drain");

    // Fairness: all four requesting, requester 0 has a second packet
    apply_reset();
    pend.push_back('{id: 2'd0, data: 8'h10, last: 1'b1});
    pend.push_back('{id: 2'd0, data: 8'h14, last: 1'b1});
    pend.push_back('{id: 2'd1, data: 8'h11, last: 1'b1});
    pend.push_back('{id: 2'd2, data: 8'h12, last: 1'b1});
    pend.push_back('{id: 2'd3, data: 8'h13, last: 1'b1});
    exp_q.push_back('{id: 2'd0, data: 8'h10, drop: 1'b0});
    exp_q.push_back('{id: 2'd1, data: 8'h11, drop: 1'b0});
    exp_q.push_back('{id: 2'd2, data: 8'h12, drop: 1'b0});
    exp_q.push_back('{id: 2'd3, data: 8'h13, drop: 1'b0});
    exp_q.push_back('{id: 2'd0, data: 8'h14, drop: 1'b0});
    wait_drain(300, "fair_drain");

    // Locked packet on requester 1 while requester 0 waits
    apply_reset();
    pend.push_back('{id: 2'd1, data: 8'h11, last: 1'b0});
    pend.push_back('{id: 2'd1, data: 8'h22, last: 1'b0});
    pend.push_back('{id: 2'd1, data: 8'h33, last: 1'b1});
    exp_q.push_back('{id: 2'd1, data: 8'h11, drop: 1'b0});
    exp_q.push_back('{id: 2'd1, data: 8'h22, drop: 1'b0});
    exp_q.push_back('{id: 2'd1, data: 8'h33, drop: 1'b0});
    exp_q.push_back('{id: 2'd0, data: 8'h44, drop: 1'b0});
    for (int c = 0; c < 10 && !bus.grant_valid; c++) begin
      @(posedge clk);
      #1;
    end
    chk("lock_first_grant", 32'(bus.grant), 1);
    pend.push_back('{id: 2'd0, data: 8'h44, last: 1'b1});
    wait_drain(300, "lock_drain");

    // Retry and drop with a dead UART
    apply_reset();
    uart_en = 1'b0;
    pend.push_back('{id: 2'd3, data: 8'h5A, last: 1'b0});
    exp_q.push_back('{id: 2'd3, data: 8'h5A, drop: 1'b1});
    cyc = 0;
    n_load = 0;
    drop_cyc = -1;
    while (drop_cyc < 0 && cyc < 120) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.uart_newTxData) begin
        if (n_load < 8) load_cyc[n_load] = cyc;
        n_load++;
      end
      if (bus.drop_err) drop_cyc = cyc;
    end
    chk("drop_load_count", 32'(n_load), 4);
    for (int i = 1; i < 4; i++) chk("retry_interval", 32'(load_cyc[i] - load_cyc[i-1]), 16);
    chk("drop_after_last_load", 32'(drop_cyc - load_cyc[3]), 16);
    @(posedge clk);
    #1;
    chk("drop_release", 32'(bus.grant_valid), 0);
    chk("drop_err_one_cycle", 32'(bus.drop_err), 0);
    uart_en = 1'b1;
    wait_drain(20, "drop_drain");

    // Hold timeout: requester 0 stalls mid-packet, requester 1 waits
    apply_reset();
    pend.push_back('{id: 2'd0, data: 8'h77, last: 1'b0});
    pend.push_back('{id: 2'd1, data: 8'h88, last: 1'b1});
    exp_q.push_back('{id: 2'd0, data: 8'h77, drop: 1'b0});
    exp_q.push_back('{id: 2'd1, data: 8'h88, drop: 1'b0});
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk);
      #1;
      if (bus.req_ack[0]) done = 1'b1;
    end
    chk("hold_first_ack", 32'(done), 1);
    cyc = 0;
    while (bus.grant_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.grant_valid) chk("hold_grant_kept", 32'(bus.grant), 0);
    end
    chk("hold_release_delay", 32'(cyc), 64);
    wait_drain(40, "hold_drain");

    // Reset during WAIT_DONE
    apply_reset();
    busy_len = 20;
    pend.push_back('{id: 2'd2, data: 8'hC3, last: 1'b1});
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk);
      #1;
      if (bus.uart_txBusy) done = 1'b1;
    end
    chk("rst_mid_busy_seen", 32'(done), 1);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_rst_outputs();
    pend.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ack_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (bus.req_ack != '0) ack_cnt++;
    end
    chk("rst_no_ack", 32'(ack_cnt), 0);
    busy_len = 6;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter N_REQ, 4, number of requesters (fixed at 4 in this revision).
REQ-002 Parameter START_TMO, 16, clk cycles to wait for uart_txBusy to rise after a load pulse.
REQ-003 Parameter MAX_RETRY, 3, load re-pulses before a byte is dropped.
REQ-004 Parameter HOLD_TMO, 64, clk cycles a locked packet may stall before the grant is released.
REQ-005 clk  in  1  system clock, 50 MHz; reset  in  1  asynchronous, active-high.
REQ-006 req  in  4  per-requester byte-valid, held high until that requester's req_ack.
REQ-007 req_data  in  32  byte of requester i on bits [8i+7:8i]; stable while req[i] high.
REQ-008 req_last  in  4  byte of requester i ends its packet.
REQ-009 req_ack  out  4  one-cycle pulse: byte of requester i fully shifted out or dropped.
REQ-010 uart_idata  out  8  byte to UART transmitter.
REQ-011 uart_newTxData  out  1  one-cycle load strobe to UART transmitter.
REQ-012 uart_txBusy  in  1  UART transmitter busy flag.
REQ-013 grant  out  2  index of current owner; grant_valid  out  1  grant meaningful.
REQ-014 drop_err  out  1  one-cycle pulse when a byte is dropped after MAX_RETRY; drop_id  out  2  its requester.

Function
REQ-015 All outputs SHALL be registered; states IDLE, LOAD, WAIT_BUSY, WAIT_DONE, ACK, HOLD.
REQ-016 IDLE: if any req, grant SHALL go to the first asserted index searching round-robin from rr_ptr+1 (mod 4); latch byte into uart_idata and req_last into a lock flag; go LOAD. Otherwise stay.
REQ-017 LOAD: uart_newTxData SHALL be 1 for exactly this one cycle; retry and timeout counters cleared; go WAIT_BUSY.
REQ-018 WAIT_BUSY: on uart_txBusy=1 go WAIT_DONE; after START_TMO cycles without it, if retries<MAX_RETRY increment retries and go LOAD, else pulse drop_err/drop_id and go ACK.
REQ-019 WAIT_DONE: on uart_txBusy=0 go ACK; no timeout in this state.
REQ-020 ACK: req_ack[grant] SHALL pulse 1 cycle; rr_ptr<=grant; if lock flag (last) set or byte dropped, grant_valid<=0 and go IDLE; else go HOLD.
REQ-021 HOLD: grant retained; requester SHALL be ignored in the ACK cycle itself; when req[grant]=1 latch byte/last and go LOAD; after HOLD_TMO cycles without req, release grant and go IDLE.
REQ-022 Other requesters SHALL NOT be granted while a packet is locked (ACK/HOLD/LOAD..WAIT_DONE).
REQ-023 Latency: req rising in IDLE at cycle N -> uart_newTxData high at N+2; ack issued 1 cycle after uart_txBusy falls is registered.
REQ-024 Simultaneous req on all lines with rr_ptr=3 SHALL grant 0, then 1, 2, 3 on successive packets.
REQ-025 A drop SHALL abort the whole packet: grant released, remaining bytes of that requester re-arbitrated as a new packet.
REQ-026 Counters SHALL saturate, never wrap: timeout counter width ceil(log2(max(START_TMO,HOLD_TMO)+1)).

Reset
REQ-027 On reset: state IDLE, rr_ptr=3, grant=0, grant_valid=0, req_ack=0, uart_newTxData=0, uart_idata=0, drop_err=0, drop_id=0, counters 0.
REQ-028 Reset mid-transfer SHALL abort without ack; the UART is reset by the same signal.

Structure
REQ-029 State encoding, N_REQ and timeout defaults SHALL live in shared package uart_pkg.
REQ-030 Round-robin priority select SHALL be sub-module rr_pick4 (req[3:0], ptr[1:0] -> idx[1:0], any).

Verification
REQ-031 Single byte: req[2]=1, data 0xA5, last=1 -> newTxData 2 cycles later, uart_idata=0xA5, req_ack[2] once after txBusy falls, grant_valid drops.
REQ-032 Fairness: req=4'b1111 all last=1 held -> grant order 0,1,2,3,0; no newTxData overlap with txBusy=1.
REQ-033 Locked packet: req[1] sends 0x11,0x22,0x33 (last on 0x33) while req[0]=1 -> req[0] not granted until after 0x33 ack.
REQ-034 Retry/drop: hold txBusy=0 -> newTxData pulses 4 times 16 cycles apart, then drop_err with drop_id=grant, req_ack pulse.
REQ-035 Hold timeout: packet byte with last=0, requester drops req -> grant released exactly 64 cycles after ACK, next requester served.
REQ-036 Reset asserted during WAIT_DONE -> all outputs at reset values asynchronously, no req_ack issued.
